// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker for the 8-bit LFSR generator: self-synchronises, then flags/counts mismatches.
// Optional macro LFSR_CHK_ZERO_DETECT_EN treats 8'h00 as a lock-up word and drives stuck_zero.
module lfsr_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 data_valid,
    input  logic [7:0]           data_in,
    input  logic                 clear_count,
    output logic                 locked,
    output logic                 error,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 stuck_zero
);

    typedef enum logic [1:0] {
        SEED = 2'd0,
        HUNT = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam logic [3:0]           LOCK_TGT = 4'(LOCK_COUNT);
    localparam logic [3:0]           LOSS_TGT = 4'(LOSS_COUNT);
    localparam logic [ERR_CNT_W-1:0] CNT_ONE  = ERR_CNT_W'(1);

    function automatic logic [7:0] prbs_next(input logic [7:0] d);
        return {d[6:0], d[1] ^ d[4] ^ d[6] ^ d[7]};
    endfunction

    state_t     state;
    logic [7:0] pred;
    logic [3:0] match_cnt;
    logic [3:0] miss_cnt;

    logic word_match;
    logic zero_block;
    logic count_err;

    assign word_match = (data_in == pred);
    assign count_err  = data_valid && (state == LOCK) && !word_match;

`ifdef LFSR_CHK_ZERO_DETECT_EN
    // All-zero is the generator lock-up value, so it may never seed or match while hunting.
    assign zero_block = (data_in == 8'h00);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stuck_zero <= 1'b0;
        end else begin
            stuck_zero <= data_valid && (data_in == 8'h00);
        end
    end
`else
    assign zero_block = 1'b0;
    assign stuck_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= SEED;
            pred      <= 8'h00;
            match_cnt <= 4'd0;
            miss_cnt  <= 4'd0;
            locked    <= 1'b0;
            error     <= 1'b0;
        end else begin
            error <= 1'b0;
            if (data_valid) begin
                case (state)
                    SEED: begin
                        if (!zero_block) begin
                            pred      <= prbs_next(data_in);
                            match_cnt <= 4'd0;
                            state     <= HUNT;
                        end
                    end
                    HUNT: begin
                        if (zero_block) begin
                            state     <= SEED;
                            match_cnt <= 4'd0;
                        end else if (word_match) begin
                            pred      <= prbs_next(pred);
                            match_cnt <= match_cnt + 4'd1;
                            if (match_cnt + 4'd1 == LOCK_TGT) begin
                                state    <= LOCK;
                                locked   <= 1'b1;
                                miss_cnt <= 4'd0;
                            end
                        end else begin
                            pred      <= prbs_next(data_in);
                            match_cnt <= 4'd0;
                        end
                    end
                    LOCK: begin
                        // Flywheel: the prediction never reseeds from received data once locked.
                        pred <= prbs_next(pred);
                        if (word_match) begin
                            miss_cnt <= 4'd0;
                        end else begin
                            error <= 1'b1;
                            if (miss_cnt + 4'd1 == LOSS_TGT) begin
                                state     <= SEED;
                                locked    <= 1'b0;
                                match_cnt <= 4'd0;
                                miss_cnt  <= 4'd0;
                            end else begin
                                miss_cnt <= miss_cnt + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state <= SEED;
                    end
                endcase
            end
        end
    end

    // A clear in the same cycle as a counted error keeps that error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= '0;
        end else if (clear_count) begin
            err_count <= count_err ? CNT_ONE : '0;
        end else if (count_err && (err_count != '1)) begin
            err_count <= err_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: directed scenarios plus randomized PRBS traffic vs. a reference model.
// Runs a 16-bit counter instance and a 4-bit counter instance side by side on the same stimulus.
module tb_lfsr_checker;

    localparam int LOCK_N = 4;
    localparam int LOSS_N = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        data_valid = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        clear_count = 1'b0;
    logic        locked, error, stuck_zero;
    logic [15:0] err_count;
    logic        locked_s, error_s, stuck_zero_s;
    logic [3:0]  err_count_s;

    lfsr_checker #(.LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N), .ERR_CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .data_valid(data_valid), .data_in(data_in),
        .clear_count(clear_count), .locked(locked), .error(error),
        .err_count(err_count), .stuck_zero(stuck_zero)
    );

    lfsr_checker #(.LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N), .ERR_CNT_W(4)) dut_small (
        .clk(clk), .reset_n(reset_n), .data_valid(data_valid), .data_in(data_in),
        .clear_count(clear_count), .locked(locked_s), .error(error_s),
        .err_count(err_count_s), .stuck_zero(stuck_zero_s)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        locked;
        logic        error;
        logic        stuck;
        logic [15:0] cnt;
        logic [3:0]  cnt_s;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference model: mode 0 = seeding, 1 = hunting, 2 = locked.
    int m_mode, m_pred, m_match, m_miss, m_cnt, m_cnt_s;
    bit m_locked;
    int gen;

    function automatic int prbsNext(input int d);
        int fb;
        fb = $countones(d & 8'hD2) % 2;
        return ((d * 2) % 256) + fb;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic modelReset();
        m_mode = 0; m_pred = 0; m_match = 0; m_miss = 0;
        m_cnt = 0; m_cnt_s = 0; m_locked = 0;
    endtask

    task automatic pushExpect(input bit err, input bit stuck);
        exp_t e;
        e.locked = m_locked;
        e.error  = err;
        e.stuck  = stuck;
        e.cnt    = m_cnt[15:0];
        e.cnt_s  = m_cnt_s[3:0];
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input bit v, input int w, input bit clr);
        bit zb, err;
        int want;
        @(negedge clk);
        reset_n     = 1'b1;
        data_valid  = v;
        data_in     = w[7:0];
        clear_count = clr;
        zb  = 0;
        err = 0;
`ifdef LFSR_CHK_ZERO_DETECT_EN
        zb = (w == 0);
`endif
        if (v) begin
            if (m_mode == 0) begin
                if (!zb) begin
                    m_pred = prbsNext(w); m_match = 0; m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (zb) begin
                    m_mode = 0; m_match = 0;
                end else if (w == m_pred) begin
                    m_match++;
                    m_pred = prbsNext(m_pred);
                    if (m_match == LOCK_N) begin
                        m_mode = 2; m_locked = 1; m_miss = 0;
                    end
                end else begin
                    m_pred = prbsNext(w); m_match = 0;
                end
            end else begin
                want   = m_pred;
                m_pred = prbsNext(m_pred);
                if (w == want) begin
                    m_miss = 0;
                end else begin
                    err = 1;
                    m_miss++;
                    if (m_miss == LOSS_N) begin
                        m_mode = 0; m_locked = 0; m_match = 0; m_miss = 0;
                    end
                end
            end
        end
        if (clr) begin
            m_cnt   = err ? 1 : 0;
            m_cnt_s = err ? 1 : 0;
        end else if (err) begin
            m_cnt   = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            m_cnt_s = (m_cnt_s < 15) ? m_cnt_s + 1 : 15;
        end
        pushExpect(err, v && zb);
    endtask

    task automatic resetDut();
        @(negedge clk);
        #2;
        reset_n     = 1'b0;
        data_valid  = 1'b0;
        clear_count = 1'b0;
        modelReset();
        #1;
        checkOutput("async_rst_locked", 32'(locked), 32'd0);
        checkOutput("async_rst_error", 32'(error), 32'd0);
        checkOutput("async_rst_count", 32'(err_count), 32'd0);
        checkOutput("async_rst_stuck", 32'(stuck_zero), 32'd0);
        checkOutput("async_rst_count_s", 32'(err_count_s), 32'd0);
        pushExpect(1'b0, 1'b0);
    endtask

    task automatic sendClean(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, gen, 1'b0);
            gen = prbsNext(gen);
        end
    endtask

    task automatic sendBad(input bit clr);
        applyStimulus(1'b1, gen ^ int'($urandom_range(1, 255)), clr);
        gen = prbsNext(gen);
    endtask

    // Monitor: every clock presents registered outputs; pop one expectation per clock.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("locked", 32'(locked), 32'(e.locked));
                checkOutput("error", 32'(error), 32'(e.error));
                checkOutput("err_count", 32'(err_count), 32'(e.cnt));
                checkOutput("stuck_zero", 32'(stuck_zero), 32'(e.stuck));
                checkOutput("err_count_w4", 32'(err_count_s), 32'(e.cnt_s));
                checkOutput("locked_w4", 32'(locked_s), 32'(e.locked));
            end
        end
    end

    initial begin
        int r;
        int drained;
        modelReset();
        gen = 'h8A;

        // Lock on the reference sequence, then single and burst corruption
        resetDut();
        sendClean(5);
        sendClean(3);
        sendBad(1'b0);
        sendClean(4);
        sendBad(1'b0);
        sendBad(1'b0);
        sendBad(1'b0);
        sendClean(5);
        sendClean(2);

        // Valid gaps inside the lock-acquisition window, then clear with coincident error
        resetDut();
        gen = 'h8A;
        sendClean(2);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, int'($urandom_range(0, 255)), 1'b0);
        sendClean(3);
        sendClean(2);
        sendBad(1'b0);
        sendBad(1'b1);
        applyStimulus(1'b0, 0, 1'b1);
        sendClean(2);

        // Repeated loss/relock cycles push the narrow counter to saturation
        for (int k = 0; k < 7; k++) begin
            sendClean(5);
            for (int j = 0; j < 3; j++) sendBad(1'b0);
        end
        applyStimulus(1'b0, 0, 1'b0);
        @(posedge clk);
        #2;
        checkOutput("sat_w4", 32'(err_count_s), 32'hF);
        checkOutput("count_w16_21", 32'(err_count), 32'd21);

        // Reset mid-lock, then an all-zero stream
        sendClean(6);
        resetDut();
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 0, 1'b0);
        gen = 'h5C;
        sendClean(6);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 999));
            if (r < 2) begin
                resetDut();
            end else if (r < 100) begin
                applyStimulus(1'b0, int'($urandom_range(0, 255)), 1'b0);
            end else if (r < 160) begin
                sendBad(($urandom_range(0, 9) == 0));
            end else if (r < 180) begin
                applyStimulus(1'b1, 0, 1'b0);
                gen = prbsNext(gen);
            end else if (r < 190) begin
                gen = int'($urandom_range(1, 255));
                sendClean(1);
            end else if (r < 200) begin
                applyStimulus(1'b1, gen, 1'b1);
                gen = prbsNext(gen);
            end else begin
                sendClean(1);
            end
        end

        drained = 0;
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) begin
                drained = 1;
                break;
            end
            @(posedge clk);
            #2;
        end
        if (!drained) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
